// File: rtl/bias_argmax_pkg.sv
// bias_argmax_pkg: sizing helpers shared by the bias/argmax pipeline, its interface and bench.
// Macro BIAS_ARGMAX_SAT_EN selects saturated 2*DW sums; otherwise sums keep 2*DW+1 bits.
package bias_argmax_pkg;

  function automatic int idx_w(input int length);
    return $clog2(length);
  endfunction

  function automatic int levels(input int length);
    return $clog2(length);
  endfunction

  function automatic int half_up(input int n);
    return (n + 1) / 2;
  endfunction

  // Element count held by a given tree level (level 0 is the biased-sum stage).
  function automatic int elems(input int length, input int level);
    int n;
    n = length;
    for (int k = 0; k < level; k++) n = half_up(n);
    return n;
  endfunction

  function automatic int offset(input int length, input int level);
    int o;
    o = 0;
    for (int k = 0; k < level; k++) o += elems(length, k);
    return o;
  endfunction

  function automatic int sum_w(input int data_width);
`ifdef BIAS_ARGMAX_SAT_EN
    return 2 * data_width;
`else
    return 2 * data_width + 1;
`endif
  endfunction

endpackage

// File: rtl/bias_argmax_pipe_if.sv
// bias_argmax_pipe_if: input vector and result handshakes of the bias/argmax pipeline.
// Result width follows BIAS_ARGMAX_SAT_EN through bias_argmax_pkg::sum_w.
interface bias_argmax_pipe_if
  import bias_argmax_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LENGTH     = 10
) ();
  localparam int SUM_W = sum_w(DATA_WIDTH);
  localparam int IDX_W = idx_w(LENGTH);

  logic                             in_valid;
  logic                             in_ready;
  logic [2*DATA_WIDTH*LENGTH-1:0]   input_data;
  logic [DATA_WIDTH*LENGTH-1:0]     biases;
  logic                             out_valid;
  logic                             out_ready;
  logic [IDX_W-1:0]                 max_idx;
  logic [LENGTH-1:0]                max_onehot;
  logic signed [SUM_W-1:0]          max_value;

  modport master (
    output in_valid, input_data, biases, out_ready,
    input  in_ready, out_valid, max_idx, max_onehot, max_value
  );

  modport slave (
    input  in_valid, input_data, biases, out_ready,
    output in_ready, out_valid, max_idx, max_onehot, max_value
  );
endinterface

// File: rtl/argmax_cmp_node.sv
// argmax_cmp_node: combinational pick of the larger of two {value, index} pairs.
module argmax_cmp_node #(
  parameter int SUM_W = 17,
  parameter int IDX_W = 4
) (
  input  logic signed [SUM_W-1:0] a_value,
  input  logic [IDX_W-1:0]        a_index,
  input  logic signed [SUM_W-1:0] b_value,
  input  logic [IDX_W-1:0]        b_index,
  output logic signed [SUM_W-1:0] win_value,
  output logic [IDX_W-1:0]        win_index
);
  logic b_wins_s;

  // Equal values resolve to the lower index regardless of which port carries it.
  always_comb begin
    b_wins_s = 1'b0;
    if (b_value > a_value) begin
      b_wins_s = 1'b1;
    end else if (b_value == a_value) begin
      b_wins_s = (b_index < a_index);
    end else begin
      b_wins_s = 1'b0;
    end
  end

  assign win_value = b_wins_s ? b_value : a_value;
  assign win_index = b_wins_s ? b_index : a_index;
endmodule

// File: rtl/bias_argmax_pipe.sv
// bias_argmax_pipe: biased-sum stage followed by a registered argmax compare tree.
// Define BIAS_ARGMAX_SAT_EN to saturate each sum to 2*DATA_WIDTH bits.
module bias_argmax_pipe
  import bias_argmax_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LENGTH     = 10
) (
  input logic               clk,
  input logic               reset_n,
  bias_argmax_pipe_if.slave bus
);
  localparam int ACC_W  = 2 * DATA_WIDTH;
  localparam int SUM_W  = sum_w(DATA_WIDTH);
  localparam int IDX_W  = idx_w(LENGTH);
  localparam int LEVELS = levels(LENGTH);
  localparam int NODES  = offset(LENGTH, LEVELS + 1);

  typedef struct packed {
    logic                    valid;
    logic signed [SUM_W-1:0] value;
    logic [IDX_W-1:0]        index;
  } node_t;

  // All tree levels live in one flat array; level k starts at offset(LENGTH, k).
  node_t node_r [NODES];
  node_t node_s [NODES];
  node_t tail_s;
  logic  en_s;

`ifdef BIAS_ARGMAX_SAT_EN
  function automatic logic [SUM_W-1:0] fit_sum(input logic [ACC_W:0] raw);
    if (raw[ACC_W] != raw[ACC_W-1]) begin
      return raw[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      return raw[ACC_W-1:0];
    end
  endfunction
`else
  function automatic logic [SUM_W-1:0] fit_sum(input logic [ACC_W:0] raw);
    return raw;
  endfunction
`endif

  for (genvar i = 0; i < LENGTH; i++) begin : g_stage0
    logic [ACC_W-1:0]      acc_s;
    logic [DATA_WIDTH-1:0] bias_s;
    logic [ACC_W:0]        raw_s;
    assign acc_s     = bus.input_data[ACC_W*i +: ACC_W];
    assign bias_s    = bus.biases[DATA_WIDTH*i +: DATA_WIDTH];
    assign raw_s     = {acc_s[ACC_W-1], acc_s}
                     + {{(DATA_WIDTH+1){bias_s[DATA_WIDTH-1]}}, bias_s};
    assign node_s[i] = {bus.in_valid, fit_sum(raw_s), IDX_W'(i)};
  end

  for (genvar k = 1; k <= LEVELS; k++) begin : g_level
    localparam int SRC_N   = elems(LENGTH, k - 1);
    localparam int SRC_OFF = offset(LENGTH, k - 1);
    localparam int DST_OFF = offset(LENGTH, k);
    for (genvar j = 0; j < elems(LENGTH, k); j++) begin : g_pair
      if (2 * j + 1 < SRC_N) begin : g_cmp
        node_t                   a_s;
        node_t                   b_s;
        logic signed [SUM_W-1:0] win_value_s;
        logic [IDX_W-1:0]        win_index_s;
        assign a_s = node_r[SRC_OFF + 2*j];
        assign b_s = node_r[SRC_OFF + 2*j + 1];
        argmax_cmp_node #(.SUM_W(SUM_W), .IDX_W(IDX_W)) u_node (
          .a_value  (a_s.value),
          .a_index  (a_s.index),
          .b_value  (b_s.value),
          .b_index  (b_s.index),
          .win_value(win_value_s),
          .win_index(win_index_s)
        );
        assign node_s[DST_OFF + j] = {a_s.valid & b_s.valid, win_value_s, win_index_s};
      end else begin : g_pass
        assign node_s[DST_OFF + j] = node_r[SRC_OFF + 2*j];
      end
    end
  end

  // Every stage advances together whenever the output slot is empty or being drained.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int n = 0; n < NODES; n++) node_r[n] <= '0;
    end else if (en_s) begin
      for (int n = 0; n < NODES; n++) node_r[n] <= node_s[n];
    end
  end

  assign tail_s         = node_r[NODES-1];
  assign en_s           = !tail_s.valid || bus.out_ready;
  assign bus.in_ready   = en_s;
  assign bus.out_valid  = tail_s.valid;
  assign bus.max_idx    = tail_s.index;
  assign bus.max_value  = tail_s.value;
  assign bus.max_onehot = tail_s.valid ? (LENGTH'(1) << tail_s.index) : '0;
endmodule

// File: tb/tb_bias_argmax_pipe.sv
// tb_bias_argmax_pipe: directed and randomized checks of bias_argmax_pipe at LENGTH 10 and 5.
// Expected results come from an integer argmax reference model (honours BIAS_ARGMAX_SAT_EN).
module tb_bias_argmax_pipe;
  import bias_argmax_pkg::*;

  localparam int SW = sum_w(8);

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  bias_argmax_pipe_if #(.DATA_WIDTH(8), .LENGTH(10)) bus10 ();
  bias_argmax_pipe_if #(.DATA_WIDTH(8), .LENGTH(5))  bus5 ();

  bias_argmax_pipe #(.DATA_WIDTH(8), .LENGTH(10)) dut10 (.clk(clk), .reset_n(reset_n), .bus(bus10));
  bias_argmax_pipe #(.DATA_WIDTH(8), .LENGTH(5))  dut5  (.clk(clk), .reset_n(reset_n), .bus(bus5));

  function automatic void model(input logic [159:0] d, input logic [79:0] b, input int n,
                                output int idx, output int val);
    int s;
    idx = 0;
    val = 0;
    for (int i = 0; i < n; i++) begin
      s = int'($signed(d[16*i +: 16])) + int'($signed(b[8*i +: 8]));
`ifdef BIAS_ARGMAX_SAT_EN
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
`endif
      if (i == 0 || s > val) begin
        idx = i;
        val = s;
      end
    end
  endfunction

  task automatic send10(input logic [159:0] d, input logic [79:0] b, output int lat, output bit tmo);
    bus10.input_data = d;
    bus10.biases     = b;
    bus10.in_valid   = 1'b1;
    bus10.out_ready  = 1'b1;
    @(posedge clk); #1;
    bus10.in_valid   = 1'b0;
    bus10.input_data = {5{$urandom()}};
    bus10.biases     = {$urandom(), $urandom(), 16'($urandom())};
    lat = 1;
    tmo = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (bus10.out_valid) begin
        tmo = 1'b0;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic send5(input logic [79:0] d, input logic [39:0] b, output int lat, output bit tmo);
    bus5.input_data = d;
    bus5.biases     = b;
    bus5.in_valid   = 1'b1;
    bus5.out_ready  = 1'b1;
    @(posedge clk); #1;
    bus5.in_valid   = 1'b0;
    bus5.input_data = {$urandom(), $urandom(), 16'($urandom())};
    lat = 1;
    tmo = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (bus5.out_valid) begin
        tmo = 1'b0;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++;
    if (bus10.out_valid !== 1'b0 || bus10.max_idx !== 4'd0 || bus10.max_onehot !== 10'd0 || bus10.max_value !== SW'(0))
      begin n_fail++; $display("FAIL reset_outputs: got v=%b idx=%0d oh=%b val=%0d expected all zero", bus10.out_valid, bus10.max_idx, bus10.max_onehot, bus10.max_value); end
    reset_n = 1'b1;
    #1;
    n_checks++;
    if (bus10.in_ready !== 1'b1 || bus5.in_ready !== 1'b1)
      begin n_fail++; $display("FAIL reset_in_ready: got %b/%b expected 1/1", bus10.in_ready, bus5.in_ready); end
    n_checks++;
    if (bus5.out_valid !== 1'b0 || bus5.max_onehot !== 5'd0)
      begin n_fail++; $display("FAIL reset_len5: got v=%b oh=%b expected 0/00000", bus5.out_valid, bus5.max_onehot); end
  endtask

  task automatic test_winner();
    logic [159:0] d;
    logic [79:0]  b;
    int lat;
    bit tmo;
    d = '0;
    b = '0;
    d[16*3 +: 16] = 16'd100;
    send10(d, b, lat, tmo);
    n_checks++; if (tmo) begin n_fail++; $display("FAIL winner_timeout: no out_valid within 20 cycles, expected 5"); end
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL winner_latency: got %0d expected 5", lat); end
    n_checks++; if (bus10.max_idx !== 4'd3) begin n_fail++; $display("FAIL winner_idx: got %0d expected 3", bus10.max_idx); end
    n_checks++; if (bus10.max_onehot !== 10'b0000001000) begin n_fail++; $display("FAIL winner_onehot: got %b expected 0000001000", bus10.max_onehot); end
    n_checks++; if (bus10.max_value !== SW'(100)) begin n_fail++; $display("FAIL winner_value: got %0d expected 100", bus10.max_value); end
    @(posedge clk); #1;
    n_checks++; if (bus10.out_valid !== 1'b0) begin n_fail++; $display("FAIL winner_single: got out_valid %b expected 0", bus10.out_valid); end
  endtask

  task automatic test_tie();
    logic [159:0] d;
    logic [79:0]  b;
    int lat;
    bit tmo;
    b = '0;
    for (int i = 0; i < 10; i++) d[16*i +: 16] = 16'hFFFB;
    d[16*2 +: 16] = 16'd50;
    d[16*7 +: 16] = 16'd50;
    send10(d, b, lat, tmo);
    n_checks++;
    if (tmo || bus10.max_idx !== 4'd2 || int'($signed(bus10.max_value)) !== 50)
      begin n_fail++; $display("FAIL tie_break: got tmo=%b idx=%0d val=%0d expected idx 2 val 50", tmo, bus10.max_idx, $signed(bus10.max_value)); end
    @(posedge clk); #1;
  endtask

  task automatic test_bias_sign_ext();
    logic [159:0] d;
    logic [79:0]  b;
    int lat;
    bit tmo;
    b = '0;
    for (int i = 0; i < 10; i++) d[16*i +: 16] = 16'h8000;
    d[16*0 +: 16] = 16'd10;
    d[16*1 +: 16] = 16'd12;
    b[8*1 +: 8]   = 8'hFF;
    send10(d, b, lat, tmo);
    n_checks++;
    if (tmo || bus10.max_idx !== 4'd1 || int'($signed(bus10.max_value)) !== 11)
      begin n_fail++; $display("FAIL bias_sign_ext: got tmo=%b idx=%0d val=%0d expected idx 1 val 11", tmo, bus10.max_idx, $signed(bus10.max_value)); end
    @(posedge clk); #1;
  endtask

  task automatic test_overflow();
    logic [159:0] d;
    logic [79:0]  b;
    int lat;
    bit tmo;
    int exp_val;
`ifdef BIAS_ARGMAX_SAT_EN
    exp_val = 32767;
`else
    exp_val = 32768;
`endif
    d = '0;
    b = '0;
    d[16*0 +: 16] = 16'h7FFF;
    b[8*0 +: 8]   = 8'h01;
    send10(d, b, lat, tmo);
    n_checks++;
    if (tmo || bus10.max_idx !== 4'd0 || int'($signed(bus10.max_value)) !== exp_val)
      begin n_fail++; $display("FAIL overflow: got tmo=%b idx=%0d val=%0d expected idx 0 val %0d", tmo, bus10.max_idx, $signed(bus10.max_value), exp_val); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [159:0] d [3];
    logic [79:0]  b [3];
    int win [3] = '{4, 9, 0};
    int e_idx [3];
    int e_val [3];
    int got_idx [$];
    int got_val [$];
    int r;
    bit seen;
    for (int v = 0; v < 3; v++) begin
      for (int ch = 0; ch < 10; ch++) begin
        r = int'($urandom_range(0, 2000)) - 1000;
        d[v][16*ch +: 16] = r[15:0];
        r = int'($urandom_range(0, 255));
        b[v][8*ch +: 8] = r[7:0];
      end
      d[v][16*win[v] +: 16] = 16'd20000;
      model(d[v], b[v], 10, e_idx[v], e_val[v]);
    end
    bus10.out_ready = 1'b1;
    for (int v = 0; v < 3; v++) begin
      bus10.input_data = d[v];
      bus10.biases     = b[v];
      bus10.in_valid   = 1'b1;
      @(posedge clk); #1;
    end
    bus10.in_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (bus10.out_valid) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL bp_timeout: no out_valid within 20 cycles"); end
    bus10.out_ready  = 1'b0;
    bus10.in_valid   = 1'b1;
    bus10.input_data = {5{$urandom()}};
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++;
      if (bus10.out_valid !== 1'b1 || bus10.max_idx !== 4'(e_idx[0]) || int'($signed(bus10.max_value)) !== e_val[0]
          || bus10.max_onehot !== (10'd1 << e_idx[0]))
        begin n_fail++; $display("FAIL bp_frozen: cycle %0d got v=%b idx=%0d val=%0d expected v=1 idx=%0d val=%0d", c, bus10.out_valid, bus10.max_idx, $signed(bus10.max_value), e_idx[0], e_val[0]); end
      n_checks++;
      if (bus10.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: cycle %0d got %b expected 0", c, bus10.in_ready); end
      @(posedge clk); #1;
    end
    bus10.in_valid  = 1'b0;
    bus10.out_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (bus10.out_valid) begin
        got_idx.push_back(int'(bus10.max_idx));
        got_val.push_back(int'($signed(bus10.max_value)));
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (got_idx.size() !== 3) begin n_fail++; $display("FAIL bp_count: got %0d results expected 3", got_idx.size()); end
    for (int v = 0; v < 3 && v < got_idx.size(); v++) begin
      n_checks++;
      if (got_idx[v] !== e_idx[v] || got_val[v] !== e_val[v])
        begin n_fail++; $display("FAIL bp_order: result %0d got idx=%0d val=%0d expected idx=%0d val=%0d", v, got_idx[v], got_val[v], e_idx[v], e_val[v]); end
    end
  endtask

  task automatic test_random_stream();
    int exp_idx [$];
    int exp_val [$];
    logic [159:0] d;
    logic [79:0]  b;
    int ei, ev, r;
    bit tie_mode;
    for (int cyc = 0; cyc < 700; cyc++) begin
      tie_mode = ($urandom_range(0, 2) == 0);
      for (int ch = 0; ch < 10; ch++) begin
        r = tie_mode ? int'($urandom_range(0, 2)) - 1 : int'($urandom());
        d[16*ch +: 16] = r[15:0];
        r = tie_mode ? int'($urandom_range(0, 1)) : int'($urandom());
        b[8*ch +: 8] = r[7:0];
      end
      bus10.input_data = d;
      bus10.biases     = b;
      bus10.in_valid   = (cyc < 600) && ($urandom_range(0, 3) != 0);
      bus10.out_ready  = (cyc >= 600) || ($urandom_range(0, 2) != 0);
      #1;
      n_checks++;
      if (bus10.in_ready !== (!bus10.out_valid || bus10.out_ready))
        begin n_fail++; $display("FAIL rnd_in_ready: cycle %0d got %b expected %b", cyc, bus10.in_ready, !bus10.out_valid || bus10.out_ready); end
      if (bus10.out_valid) begin
        n_checks++;
        if (exp_idx.size() == 0) begin
          n_fail++; $display("FAIL rnd_extra: cycle %0d got result idx=%0d expected none", cyc, bus10.max_idx);
        end else if (bus10.max_idx !== 4'(exp_idx[0]) || int'($signed(bus10.max_value)) !== exp_val[0]
                     || bus10.max_onehot !== (10'd1 << exp_idx[0])) begin
          n_fail++; $display("FAIL rnd_result: cycle %0d got idx=%0d val=%0d oh=%b expected idx=%0d val=%0d", cyc, bus10.max_idx, $signed(bus10.max_value), bus10.max_onehot, exp_idx[0], exp_val[0]);
        end
        if (bus10.out_ready && exp_idx.size() != 0) begin
          ei = exp_idx.pop_front();
          ev = exp_val.pop_front();
        end
      end
      if (bus10.in_valid && bus10.in_ready) begin
        model(d, b, 10, ei, ev);
        exp_idx.push_back(ei);
        exp_val.push_back(ev);
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (exp_idx.size() !== 0) begin n_fail++; $display("FAIL rnd_lost: got %0d results outstanding expected 0", exp_idx.size()); end
  endtask

  task automatic test_odd_length_reset();
    logic [79:0] d;
    logic [39:0] b;
    int lat, ei, ev, r, stale;
    bit tmo, seen;
    for (int ch = 0; ch < 5; ch++) begin
      r = int'($urandom_range(0, 100));
      d[16*ch +: 16] = r[15:0];
      r = int'($urandom_range(0, 255));
      b[8*ch +: 8] = r[7:0];
    end
    d[16*4 +: 16] = 16'd500;
    model({80'd0, d}, {40'd0, b}, 5, ei, ev);
    send5(d, b, lat, tmo);
    n_checks++; if (tmo || lat !== 4) begin n_fail++; $display("FAIL odd_latency: got tmo=%b lat=%0d expected 4", tmo, lat); end
    n_checks++;
    if (bus5.max_idx !== 3'd4 || bus5.max_onehot !== 5'b10000 || int'($signed(bus5.max_value)) !== ev)
      begin n_fail++; $display("FAIL odd_result: got idx=%0d oh=%b val=%0d expected idx=4 oh=10000 val=%0d", bus5.max_idx, bus5.max_onehot, $signed(bus5.max_value), ev); end
    @(posedge clk); #1;
    bus5.out_ready = 1'b0;
    for (int v = 0; v < 2; v++) begin
      bus5.input_data = {$urandom(), $urandom(), 16'($urandom())};
      bus5.in_valid   = 1'b1;
      @(posedge clk); #1;
    end
    bus5.in_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (bus5.out_valid) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL odd_inflight: no out_valid within 20 cycles"); end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (bus5.out_valid !== 1'b0 || bus5.max_idx !== 3'd0 || bus5.max_onehot !== 5'd0 || bus5.max_value !== SW'(0) || bus5.in_ready !== 1'b1)
      begin n_fail++; $display("FAIL odd_async_reset: got v=%b idx=%0d oh=%b val=%0d rdy=%b expected 0/0/0/0/1", bus5.out_valid, bus5.max_idx, bus5.max_onehot, bus5.max_value, bus5.in_ready); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    bus5.out_ready = 1'b1;
    stale = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (bus5.out_valid !== 1'b0) stale++;
      @(posedge clk); #1;
    end
    n_checks++; if (stale !== 0) begin n_fail++; $display("FAIL odd_stale: got %0d cycles with out_valid expected 0", stale); end
    d = '0;
    b = '0;
    d[16*1 +: 16] = 16'd7;
    send5(d, b, lat, tmo);
    n_checks++;
    if (tmo || lat !== 4 || bus5.max_idx !== 3'd1 || int'($signed(bus5.max_value)) !== 7)
      begin n_fail++; $display("FAIL odd_after_reset: got tmo=%b lat=%0d idx=%0d val=%0d expected lat 4 idx 1 val 7", tmo, lat, bus5.max_idx, $signed(bus5.max_value)); end
    @(posedge clk); #1;
  endtask

  initial begin
    bus10.in_valid   = 1'b0;
    bus10.out_ready  = 1'b1;
    bus10.input_data = '0;
    bus10.biases     = '0;
    bus5.in_valid    = 1'b0;
    bus5.out_ready   = 1'b1;
    bus5.input_data  = '0;
    bus5.biases      = '0;
    test_reset();
    test_winner();
    test_tie();
    test_bias_sign_ext();
    test_overflow();
    test_backpressure();
    test_random_stream();
    test_odd_length_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
